cordic_scheduler: RTL and testbench

Shares one cordic_rotator instance among NUM_REQ requesters, for example per-channel NCO phase sources in the colour-decode path. Each cycle a round-robin arbiter grants one requester. The block folds the requested angle into the rotator's convergent range (±90°), tracks a tag alongside the untagged rotator pipeline, and applies a sign correction to the result. It returns sin/cos with the requester ID, at full throughput of one result per cycle.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_rotator.sv | 77 +++++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/cordic_scheduler.sv | 107 ++++++++++
 tb/tb_cordic_scheduler.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared angle constants, pipeline tag type and saturating negate for the CORDIC scheduler.
package cordic_pkg;

    localparam int ANGLE_WIDTH  = 20;
    localparam int TAG_ID_WIDTH = 3;

    localparam logic [ANGLE_WIDTH-1:0] DEG_90  = 20'd262144;
    localparam logic [ANGLE_WIDTH-1:0] DEG_180 = 20'd524288;

    typedef struct packed {
        logic                    vld;
        logic [TAG_ID_WIDTH-1:0] id;
        logic                    neg;
    } tag_t;

    // Two's-complement negate that maps the most negative code to the most positive one.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] value, input int width);
        logic signed [31:0] maxPos;
        maxPos = (32'sd1 <<< (width - 1)) - 32'sd1;
        return (-value > maxPos) ? maxPos : -value;
    endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Untagged pipelined CORDIC rotator (rotation mode) for angles within +/-90 degrees.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int STAGES     = 16
) (
    input  logic                          clk,
    input  logic [ANGLE_WIDTH-1:0]        target_angle,
    output logic signed [DATA_WIDTH-1:0]  sin_out,
    output logic signed [DATA_WIDTH-1:0]  cos_out
);

    localparam int GUARD = 4;
    localparam int IW    = DATA_WIDTH + GUARD + 1;
    localparam logic signed [IW-1:0] AMP   = IW'((2 ** (DATA_WIDTH - 1)) * 75 / 128 * (2 ** GUARD));
    localparam logic signed [IW-1:0] ROUND = IW'(2 ** (GUARD - 1));

    logic signed [IW-1:0]          r_x [0:STAGES-1];
    logic signed [IW-1:0]          r_y [0:STAGES-1];
    logic signed [ANGLE_WIDTH-1:0] r_z [0:STAGES-1];
    logic signed [IW-1:0]          w_xRnd;
    logic signed [IW-1:0]          w_yRnd;
    logic                          w_unused;

    // atan(2^-i) in angle units where 2^20 is a full turn.
    function automatic logic signed [ANGLE_WIDTH-1:0] atanEntry(input int i);
        case (i)
            0:  return 20'sd131072;
            1:  return 20'sd77376;
            2:  return 20'sd40884;
            3:  return 20'sd20753;
            4:  return 20'sd10417;
            5:  return 20'sd5213;
            6:  return 20'sd2607;
            7:  return 20'sd1304;
            8:  return 20'sd652;
            9:  return 20'sd326;
            10: return 20'sd163;
            11: return 20'sd81;
            12: return 20'sd41;
            13: return 20'sd20;
            14: return 20'sd10;
            15: return 20'sd5;
            default: return 20'sd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        r_x[0] <= AMP;
        if (target_angle[ANGLE_WIDTH-1]) begin
            r_y[0] <= -AMP;
            r_z[0] <= $signed(target_angle) + atanEntry(0);
        end else begin
            r_y[0] <= AMP;
            r_z[0] <= $signed(target_angle) - atanEntry(0);
        end
        for (int k = 1; k < STAGES; k++) begin
            if (r_z[k-1][ANGLE_WIDTH-1]) begin
                r_x[k] <= r_x[k-1] + (r_y[k-1] >>> k);
                r_y[k] <= r_y[k-1] - (r_x[k-1] >>> k);
                r_z[k] <= r_z[k-1] + atanEntry(k);
            end else begin
                r_x[k] <= r_x[k-1] - (r_y[k-1] >>> k);
                r_y[k] <= r_y[k-1] + (r_x[k-1] >>> k);
                r_z[k] <= r_z[k-1] - atanEntry(k);
            end
        end
    end

    assign w_xRnd   = r_x[STAGES-1] + ROUND;
    assign w_yRnd   = r_y[STAGES-1] + ROUND;
    assign cos_out  = w_xRnd[GUARD +: DATA_WIDTH];
    assign sin_out  = w_yRnd[GUARD +: DATA_WIDTH];
    assign w_unused = ^{w_xRnd[GUARD-1:0], w_xRnd[IW-1], w_yRnd[GUARD-1:0], w_yRnd[IW-1], r_z[STAGES-1]};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after the pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_nextPtr;
    int            w_idx;

    // Scan offsets from the far end so the closest active requester is written last and wins.
    always_comb begin
        grant     = '0;
        w_nextPtr = r_ptr;
        w_idx     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = (int'(r_ptr) + i) % N;
            if (req[PW'(w_idx)]) begin
                grant            = '0;
                grant[PW'(w_idx)] = 1'b1;
                w_nextPtr        = PW'((w_idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_nextPtr;
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one CORDIC rotator among NUM_REQ requesters with quadrant folding and tagged results.
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 12,
    parameter int STAGES     = 16,
    parameter int LATENCY    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
    output logic                           rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic signed [DATA_WIDTH-1:0]   rsp_sin,
    output logic signed [DATA_WIDTH-1:0]   rsp_cos
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            w_grant;
    logic                          w_accept;
    logic [IDW-1:0]                w_gid;
    logic [ANGLE_WIDTH-1:0]        w_angle;
    logic [ANGLE_WIDTH-1:0]        w_folded;
    logic                          w_neg;
    logic signed [DATA_WIDTH-1:0]  w_rotSin;
    logic signed [DATA_WIDTH-1:0]  w_rotCos;
    logic signed [DATA_WIDTH-1:0]  w_negSin;
    logic signed [DATA_WIDTH-1:0]  w_negCos;
    logic                          w_unused;
    logic [ANGLE_WIDTH-1:0]        r_rotAngle;
    // Entry 0 parallels r_rotAngle; entries 1..LATENCY track the rotator's stages.
    tag_t                          r_tag [0:LATENCY];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_accept),
        .grant   (w_grant)
    );

    cordic_rotator #(.DATA_WIDTH(DATA_WIDTH), .STAGES(STAGES)) u_rot (
        .clk          (clk),
        .target_angle (r_rotAngle),
        .sin_out      (w_rotSin),
        .cos_out      (w_rotCos)
    );

    assign req_ready = rst ? '0 : w_grant;
    assign w_accept  = |(req_valid & req_ready);

    always_comb begin
        w_gid   = '0;
        w_angle = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gid   = IDW'(i);
                w_angle = req_angle[ANGLE_WIDTH*i +: ANGLE_WIDTH];
            end
        end
    end

    // Angles in the outer half-plane are turned by 180 degrees; the result is negated on the way out.
    assign w_neg    = w_angle[ANGLE_WIDTH-1] ^ w_angle[ANGLE_WIDTH-2];
    assign w_folded = w_neg ? (w_angle + DEG_180) : w_angle;
    assign w_negSin = DATA_WIDTH'(sat_neg(32'(w_rotSin), DATA_WIDTH));
    assign w_negCos = DATA_WIDTH'(sat_neg(32'(w_rotCos), DATA_WIDTH));
    assign w_unused = ^r_tag[LATENCY].id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rotAngle <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_rotAngle   <= w_accept ? w_folded : '0;
            r_tag[0].vld <= w_accept;
            r_tag[0].id  <= TAG_ID_WIDTH'(w_gid);
            r_tag[0].neg <= w_accept & w_neg;
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sin   <= '0;
            rsp_cos   <= '0;
        end else begin
            rsp_valid <= r_tag[LATENCY].vld;
            if (r_tag[LATENCY].vld) begin
                rsp_id  <= r_tag[LATENCY].id[IDW-1:0];
                rsp_sin <= r_tag[LATENCY].neg ? w_negSin : w_rotSin;
                rsp_cos <= r_tag[LATENCY].neg ? w_negCos : w_rotCos;
            end
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler: round-robin grant model plus ideal K*A*sin/cos reference.
module tb_cordic_scheduler;
    import cordic_pkg::*;

    localparam int  NUM_REQ    = 4;
    localparam int  DATA_WIDTH = 12;
    localparam int  STAGES     = 16;
    localparam int  LATENCY    = 16;
    localparam real AMP        = 1200.0;
    localparam int  TOL        = 3;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic [NUM_REQ-1:0]             req_valid = '0;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle = '0;
    logic                           rsp_valid;
    logic [1:0]                     rsp_id;
    logic signed [DATA_WIDTH-1:0]   rsp_sin;
    logic signed [DATA_WIDTH-1:0]   rsp_cos;

    typedef struct {
        int id;
        int angle;
        int due;
    } exp_t;

    exp_t                   sb[$];
    exp_t                   monE;
    int                     cyc = 0;
    int                     total = 0;
    int                     bad = 0;
    int                     modelPtr = 0;
    bit                     monEn = 1'b0;
    real                    kGain;
    logic [ANGLE_WIDTH-1:0] stimAngle [NUM_REQ];

    cordic_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (STAGES),
        .LATENCY    (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_angle (req_angle),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int roundToInt(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int expSin(input int a);
        return roundToInt(kGain * AMP * $sin(real'(a) * 2.0 * 3.141592653589793 / 1048576.0));
    endfunction

    function automatic int expCos(input int a);
        return roundToInt(kGain * AMP * $cos(real'(a) * 2.0 * 3.141592653589793 / 1048576.0));
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp, input int tol);
        total++;
        if (act > exp + tol || act < exp - tol) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    // Drive one cycle, predict the grant, and queue the expected response for any accept.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic r, output int gId);
        int expGrant;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_angle[ANGLE_WIDTH*i +: ANGLE_WIDTH] = stimAngle[i];
        end
        #1;
        gId = -1;
        if (!r) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (modelPtr + k) % NUM_REQ;
                if (gId < 0 && v[idx]) gId = idx;
            end
        end
        expGrant = (gId >= 0) ? (1 << gId) : 0;
        checkOutput(r ? "ready_in_reset" : "grant", int'(req_ready), expGrant, 0);
        if (r) begin
            sb.delete();
            modelPtr = 0;
        end else if (gId >= 0) begin
            sb.push_back('{id: gId, angle: int'($signed(stimAngle[gId])), due: cyc + LATENCY + 2});
            modelPtr = (gId + 1) % NUM_REQ;
        end
    endtask

    task automatic checkFold(input logic [ANGLE_WIDTH-1:0] a, input int expRot, input string name);
        int g;
        stimAngle[0] = a;
        applyStimulus(4'b0001, 1'b0, g);
        applyStimulus(4'b0000, 1'b0, g);
        checkOutput(name, int'(dut.r_rotAngle), expRot, 0);
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                monE = sb.pop_front();
                checkOutput("rsp_valid", int'(rsp_valid), 1, 0);
                checkOutput("rsp_id", int'(rsp_id), monE.id, 0);
                checkOutput("rsp_sin", int'(rsp_sin), expSin(monE.angle), TOL);
                checkOutput("rsp_cos", int'(rsp_cos), expCos(monE.angle), TOL);
            end else begin
                checkOutput("idle_rsp_valid", int'(rsp_valid), 0, 0);
            end
        end
    end

    initial begin
        int                 g;
        int                 tries;
        logic [NUM_REQ-1:0] v;

        kGain = 1.0;
        for (int i = 0; i < STAGES; i++) kGain = kGain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        for (int i = 0; i < NUM_REQ; i++) stimAngle[i] = '0;

        $display("[TB] reset with all requesters active");
        repeat (3) applyStimulus(4'hF, 1'b1, g);
        applyStimulus(4'h0, 1'b0, g);
        checkOutput("reset_rsp_valid", int'(rsp_valid), 0, 0);
        checkOutput("reset_rsp_sin", int'(rsp_sin), 0, 0);
        checkOutput("reset_rsp_cos", int'(rsp_cos), 0, 0);
        checkOutput("reset_rot_angle", int'(dut.r_rotAngle), 0, 0);
        monEn = 1'b1;

        $display("[TB] single request and fold cases");
        stimAngle[2] = 20'h00000;
        applyStimulus(4'b0100, 1'b0, g);
        applyStimulus(4'b0000, 1'b0, g);
        checkOutput("rot_angle_zero", int'(dut.r_rotAngle), 0, 0);
        checkFold(20'h60000, 32'h000E0000, "fold_135");
        checkFold(20'hA0000, 32'h00020000, "fold_m135");
        checkFold(20'h40000, 32'h000C0000, "fold_p90");
        checkFold(20'h80000, 32'h00000000, "fold_m180");
        checkFold(20'h3FFFF, 32'h0003FFFF, "fold_edge");
        checkOutput("sat_neg_min", int'($signed(DATA_WIDTH'(sat_neg(-32'sd2048, DATA_WIDTH)))), 2047, 0);
        checkOutput("sat_neg_pos", int'($signed(DATA_WIDTH'(sat_neg(32'sd2047, DATA_WIDTH)))), -2047, 0);
        checkOutput("sat_neg_small", int'($signed(DATA_WIDTH'(sat_neg(-32'sd5, DATA_WIDTH)))), 5, 0);

        $display("[TB] all requesters active for 40 cycles");
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NUM_REQ; i++) stimAngle[i] = ANGLE_WIDTH'($urandom());
            applyStimulus(4'hF, 1'b0, g);
        end

        $display("[TB] reset with requests in flight");
        stimAngle[0] = 20'h12345;
        repeat (5) applyStimulus(4'b0001, 1'b0, g);
        applyStimulus(4'hF, 1'b1, g);
        repeat (LATENCY + 5) applyStimulus(4'h0, 1'b0, g);
        stimAngle[2] = 20'h15555;
        applyStimulus(4'b0100, 1'b0, g);

        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) stimAngle[i] = ANGLE_WIDTH'($urandom());
            applyStimulus(NUM_REQ'($urandom_range(0, 15)), 1'b0, g);
        end

        $display("[TB] angle sweep on ch1 with sparse ch3");
        for (int a = -524288; a <= 524288; a += 524) begin
            stimAngle[1] = a[ANGLE_WIDTH-1:0];
            v = 4'b0010;
            if ($urandom_range(0, 7) == 0) begin
                v[3]         = 1'b1;
                stimAngle[3] = ANGLE_WIDTH'($urandom());
            end
            tries = 0;
            do begin
                applyStimulus(v, 1'b0, g);
                if (g >= 0) v[g] = 1'b0;
                tries++;
            end while (v[1] && tries < 4);
            checkOutput("sweep_accepted", int'(v[1]), 0, 0);
        end

        repeat (LATENCY + 4) applyStimulus(4'h0, 1'b0, g);
        checkOutput("scoreboard_drained", sb.size(), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
